// File: rtl/sliding_error_corrector.sv
// Applies per-position 2-bit correction codes to a sliced bitstream, holding one
// frame so a code at position 0 can still fix the last bit of the previous frame.
module sliding_error_corrector #(
   parameter int unsigned width = 16,
   parameter int unsigned cnt_w = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid_in,
   input  logic [width-1:0]     i_bits_in,
   input  logic [2*width-1:0]   i_mmse_err_pos,
   input  logic                 i_en_corr,
   input  logic                 i_clr_cnt,
   output logic [width-1:0]     o_bits_out,
   output logic                 o_valid_out,
   output logic [cnt_w-1:0]     o_flip_count
);

   localparam int unsigned PC_W  = $clog2(width + 1) + 1;
   localparam int unsigned SUM_W = ((cnt_w > PC_W) ? cnt_w : PC_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({cnt_w{1'b1}});

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [width-1:0]    r_hold;
   logic [width-1:0]    w_hold_nxt;
   logic [width-1:0]    r_bits_out;
   logic [width-1:0]    w_bits_nxt;
   logic                r_valid_out;
   logic                w_valid_nxt;
   logic [cnt_w-1:0]    r_flip_count;
   logic [cnt_w-1:0]    w_cnt_nxt;

   logic [width-1:0]    w_req_here;
   logic [width-1:0]    w_req_prev;
   logic [width-1:0]    w_mask;
   logic                w_cross;
   logic [PC_W-1:0]     w_pop;
   logic [SUM_W-1:0]    w_headroom;
   logic [cnt_w-1:0]    w_cnt_sat;

   // Split each code into "flip this bit" (bit 0) and "flip previous bit" (bit 1).
   always_comb begin
      w_req_here = '0;
      w_req_prev = '0;
      for (int i = 0; i < int'(width); i++) begin
         w_req_here[i] = i_en_corr & i_mmse_err_pos[2*i];
         w_req_prev[i] = i_en_corr & i_mmse_err_pos[2*i+1];
      end
   end

   // OR-merge so a bit requested from both neighbours flips only once.
   assign w_mask  = w_req_here | {1'b0, w_req_prev[width-1:1]};
   assign w_cross = (r_state == ST_HOLD) & w_req_prev[0];

   always_comb begin
      w_pop = PC_W'(w_cross);
      for (int i = 0; i < int'(width); i++) begin
         w_pop = w_pop + PC_W'(w_mask[i]);
      end
   end

   // Saturating add: check headroom first so the count never wraps.
   assign w_headroom = CNT_MAX - SUM_W'(r_flip_count);
   assign w_cnt_sat  = (SUM_W'(w_pop) > w_headroom) ? cnt_w'(CNT_MAX)
                                                     : r_flip_count + cnt_w'(w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_EMPTY;
         r_hold       <= '0;
         r_bits_out   <= '0;
         r_valid_out  <= 1'b0;
         r_flip_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold       <= w_hold_nxt;
         r_bits_out   <= w_bits_nxt;
         r_valid_out  <= w_valid_nxt;
         r_flip_count <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_bits_nxt  = r_bits_out;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = r_flip_count;

      if (i_valid_in) begin
         w_hold_nxt  = i_bits_in ^ w_mask;
         w_state_nxt = ST_HOLD;
         w_cnt_nxt   = w_cnt_sat;
         case (r_state)
            ST_EMPTY: begin
               w_valid_nxt = 1'b0;
            end
            ST_HOLD: begin
               w_bits_nxt  = r_hold ^ {w_cross, {(width-1){1'b0}}};
               w_valid_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end

      if (i_clr_cnt) begin
         w_cnt_nxt = '0;
      end
   end

   assign o_bits_out   = r_bits_out;
   assign o_valid_out  = r_valid_out;
   assign o_flip_count = r_flip_count;

endmodule

// File: tb/tb_sliding_error_corrector.sv
// Table-driven bench with an emitted-frame scoreboard; a second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_sliding_error_corrector;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [15:0] bits_in;
   logic [31:0] codes;
   logic        en_corr;
   logic        clr_cnt;
   logic [15:0] bits_out, s_bits_out;
   logic        valid_out, s_valid_out;
   logic [15:0] flip_count;
   logic [3:0]  s_flip_count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] bits;
      logic [31:0] codes;
      logic        vin;
      logic        en;
      logic        clr;
      logic        ev;
      logic [15:0] eb;
      logic [15:0] ec;
      logic [3:0]  ecs;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] sb_q[$];

   sliding_error_corrector #(.width(16), .cnt_w(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid_in(valid_in), .i_bits_in(bits_in),
      .i_mmse_err_pos(codes), .i_en_corr(en_corr), .i_clr_cnt(clr_cnt),
      .o_bits_out(bits_out), .o_valid_out(valid_out), .o_flip_count(flip_count)
   );

   sliding_error_corrector #(.width(16), .cnt_w(4)) u_small (
      .i_clk(clk), .i_rst(rst), .i_valid_in(valid_in), .i_bits_in(bits_in),
      .i_mmse_err_pos(codes), .i_en_corr(en_corr), .i_clr_cnt(clr_cnt),
      .o_bits_out(s_bits_out), .o_valid_out(s_valid_out), .o_flip_count(s_flip_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] cd(int pos, logic [1:0] v);
      return 32'(v) << (2 * pos);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic addv(logic [15:0] b, logic [31:0] c, logic vin, logic en, logic clr,
                       logic ev, logic [15:0] eb, logic [15:0] ec, logic [3:0] ecs);
      vec_t v;
      v.bits = b; v.codes = c; v.vin = vin; v.en = en; v.clr = clr;
      v.ev = ev; v.eb = eb; v.ec = ec; v.ecs = ecs;
      vecs.push_back(v);
   endtask

   task automatic drive(logic r, logic vin, logic [15:0] b, logic [31:0] c, logic en, logic clr);
      rst = r; valid_in = vin; bits_in = b; codes = c; en_corr = en; clr_cnt = clr;
   endtask

   // Check one output cycle: valid flag, then the popped frame or the held bits.
   task automatic check_out(string tag, logic ev, logic [15:0] hold_bits);
      check({tag, "_valid"}, 32'(valid_out), 32'(ev));
      check({tag, "_s_valid"}, 32'(s_valid_out), 32'(ev));
      if (valid_out) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_sb_underflow: got unexpected frame %h expected none", tag, bits_out);
         end else begin
            check({tag, "_bits"}, 32'(bits_out), 32'(sb_q.pop_front()));
         end
      end else begin
         check({tag, "_hold_bits"}, 32'(bits_out), 32'(hold_bits));
         if (ev && sb_q.size() > 0) void'(sb_q.pop_front());
      end
   endtask

   initial begin
      // Test 1..6 sequences: bits, codes, vin, en, clr, exp_valid, exp_bits, exp_cnt, exp_cnt4
      addv(16'h0000, 32'h0,               1, 1, 0, 0, 16'h0000, 16'd0,  4'd0);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0000, 16'd0,  4'd0);
      addv(16'h0000, cd(5, 2'd1),         1, 1, 0, 1, 16'h0000, 16'd1,  4'd1);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0020, 16'd1,  4'd1);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0000, 16'd1,  4'd1);
      addv(16'h0000, cd(0, 2'd2),         1, 1, 0, 1, 16'h8000, 16'd2,  4'd2);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0000, 16'd2,  4'd2);
      addv(16'h0000, cd(3, 2'd1) | cd(4, 2'd2), 1, 1, 0, 1, 16'h0000, 16'd3, 4'd3);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0008, 16'd3,  4'd3);
      addv(16'h0000, cd(4, 2'd3),         1, 1, 0, 1, 16'h0000, 16'd5,  4'd5);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0018, 16'd5,  4'd5);
      addv(16'h1234, 32'hFFFF_FFFF,       1, 0, 0, 1, 16'h0000, 16'd5,  4'd5);
      addv(16'hABCD, 32'hFFFF_FFFF,       1, 0, 0, 1, 16'h1234, 16'd5,  4'd5);
      addv(16'h5A5A, 32'h0,               1, 1, 0, 1, 16'hABCD, 16'd5,  4'd5);
      addv(16'h0000, 32'hFFFF_FFFF,       0, 1, 0, 0, 16'hABCD, 16'd5,  4'd5);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h5A5A, 16'd5,  4'd5);
      addv(16'h0000, 32'hFFFF_FFFF,       1, 1, 0, 1, 16'h8000, 16'd22, 4'd15);
      addv(16'hFFFF, 32'h0,               1, 1, 0, 1, 16'hFFFF, 16'd22, 4'd15);
      addv(16'h0000, cd(2, 2'd1),         1, 1, 1, 1, 16'hFFFF, 16'd0,  4'd0);
      addv(16'h0000, 32'h0,               1, 1, 0, 1, 16'h0004, 16'd0,  4'd0);
      addv(16'h0000, 32'hFFFF_FFFF,       1, 1, 0, 1, 16'h8000, 16'd17, 4'd15);
      addv(16'h0000, cd(0, 2'd1) | cd(1, 2'd1) | cd(2, 2'd1), 1, 1, 0, 1, 16'hFFFF, 16'd20, 4'd15);

      // Reset with a frame offered: it must be ignored.
      drive(1, 1, 16'hFFFF, 32'hFFFF_FFFF, 1, 0);
      @(posedge clk); #1;
      check_out("reset", 1'b0, 16'h0000);
      check("reset_cnt", 32'(flip_count), 32'd0);
      check("reset_cnt4", 32'(s_flip_count), 32'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(0, vecs[i].vin, vecs[i].bits, vecs[i].codes, vecs[i].en, vecs[i].clr);
         if (vecs[i].ev) sb_q.push_back(vecs[i].eb);
         @(posedge clk); #1;
         check_out($sformatf("v%0d", i), vecs[i].ev, vecs[i].eb);
         check($sformatf("v%0d_cnt", i), 32'(flip_count), 32'(vecs[i].ec));
         check($sformatf("v%0d_cnt4", i), 32'(s_flip_count), 32'(vecs[i].ecs));
      end

      // Reset while holding 0x0007: the held frame must never appear.
      drive(1, 1, 16'h1111, 32'hFFFF_FFFF, 1, 0);
      @(posedge clk); #1;
      check_out("midrst", 1'b0, 16'h0000);
      check("midrst_cnt", 32'(flip_count), 32'd0);
      check("midrst_cnt4", 32'(s_flip_count), 32'd0);

      // First frame after reset is held; its code[0]=2 has no target and is not counted.
      drive(0, 1, 16'h00F0, cd(0, 2'd2), 1, 0);
      @(posedge clk); #1;
      check_out("post1", 1'b0, 16'h0000);
      check("post1_cnt", 32'(flip_count), 32'd0);
      check("post1_cnt4", 32'(s_flip_count), 32'd0);

      drive(0, 1, 16'h0000, 32'h0, 1, 0);
      sb_q.push_back(16'h00F0);
      @(posedge clk); #1;
      check_out("post2", 1'b1, 16'h00F0);
      check("post2_cnt", 32'(flip_count), 32'd0);

      drive(0, 0, 16'h0000, 32'h0, 1, 0);
      @(posedge clk); #1;
      check_out("idle", 1'b0, 16'h00F0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
